// File: rtl/pf_queue_if.sv
// Push, pop and lookup handshake bundle for pf_queue_ctrl.
// master: producer/consumer side; slave: the queue itself.
interface pf_queue_if #(
    parameter int unsigned LOG_DEPTH  = 6,
    parameter int unsigned ADDR_WIDTH = 64
);
    logic                  push_valid;
    logic                  push_ready;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic                  pop_valid;
    logic                  pop_ready;
    logic [ADDR_WIDTH-1:0] pop_addr;
    logic                  lookup_valid;
    logic [ADDR_WIDTH-1:0] lookup_addr;
    logic                  lookup_hit;
    logic [LOG_DEPTH-1:0]  lookup_idx;

    modport master (
        output push_valid, push_addr, pop_ready, lookup_valid, lookup_addr,
        input  push_ready, pop_valid, pop_addr, lookup_hit, lookup_idx
    );

    modport slave (
        input  push_valid, push_addr, pop_ready, lookup_valid, lookup_addr,
        output push_ready, pop_valid, pop_addr, lookup_hit, lookup_idx
    );
endinterface

// File: rtl/pf_queue_ctrl.sv
// Circular prefetch-address queue: head/tail pointers, occupancy flags,
// valid/ready push/pop and a one-cycle registered oldest-match lookup.
// Optional macro PF_QUEUE_OVERWRITE_EN: a push into a full queue overwrites
// the oldest entry and pulses dropped instead of back-pressuring.
module pf_queue_ctrl #(
    parameter int unsigned LOG_DEPTH  = 6,
    parameter int unsigned DEPTH      = 1 << LOG_DEPTH,
    parameter int unsigned ADDR_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pf_queue_if.slave            bus,
    output logic [LOG_DEPTH-1:0] headIdx,
    output logic [LOG_DEPTH-1:0] tailIdx,
    output logic [LOG_DEPTH:0]   count,
    output logic                 empty,
    output logic                 full,
    output logic                 dropped
);
    localparam int unsigned CW = LOG_DEPTH + 1;

    logic [ADDR_WIDTH-1:0] r_mem [DEPTH];
    logic [LOG_DEPTH-1:0]  r_head;
    logic [LOG_DEPTH-1:0]  r_tail;
    logic [CW-1:0]         r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_dropped;
    logic                  r_lookup_hit;
    logic [LOG_DEPTH-1:0]  r_lookup_idx;

    logic                  w_push_ready;
    logic                  w_pop_valid;
    logic                  w_push_fire;
    logic                  w_pop_fire;
    logic                  w_drop;
    logic [CW-1:0]         w_count_nxt;
    logic                  w_lookup_hit;
    logic [LOG_DEPTH-1:0]  w_lookup_idx;
    logic [LOG_DEPTH-1:0]  w_slot;

    // Ready/valid depend only on registered flags, never on the opposite port
`ifdef PF_QUEUE_OVERWRITE_EN
    assign w_push_ready = 1'b1;
    assign w_drop       = w_push_fire & r_full & ~w_pop_fire;
`else
    assign w_push_ready = ~r_full;
    assign w_drop       = 1'b0;
`endif
    assign w_pop_valid  = ~r_empty;
    assign w_push_fire  = bus.push_valid & w_push_ready;
    assign w_pop_fire   = w_pop_valid & bus.pop_ready;

    // Occupancy update; an overwrite keeps the count pinned at DEPTH
    always_comb begin
        w_count_nxt = r_count;
        if (w_push_fire && !w_pop_fire && !w_drop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push_fire && w_pop_fire) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Oldest-match search: walk youngest to oldest so the slot nearest head wins
    always_comb begin
        w_lookup_hit = 1'b0;
        w_lookup_idx = '0;
        w_slot       = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            w_slot = r_head + LOG_DEPTH'(k);
            if ((CW'(k) < r_count) && (r_mem[w_slot] == bus.lookup_addr)) begin
                w_lookup_hit = 1'b1;
                w_lookup_idx = w_slot;
            end
        end
    end

    // Pointer, flag and lookup-result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
            r_dropped    <= 1'b0;
            r_lookup_hit <= 1'b0;
            r_lookup_idx <= '0;
        end else if (flush) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
            r_dropped    <= 1'b0;
            r_lookup_hit <= 1'b0;
        end else begin
            if (w_push_fire) begin
                r_tail <= r_tail + LOG_DEPTH'(1);
            end
            if (w_pop_fire || w_drop) begin
                r_head <= r_head + LOG_DEPTH'(1);
            end
            r_count      <= w_count_nxt;
            r_empty      <= (w_count_nxt == '0);
            r_full       <= (w_count_nxt == CW'(DEPTH));
            r_dropped    <= w_drop;
            r_lookup_hit <= bus.lookup_valid & w_lookup_hit;
            if (bus.lookup_valid && w_lookup_hit) begin
                r_lookup_idx <= w_lookup_idx;
            end
        end
    end

    // Entry storage, deliberately left unreset
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push_fire) begin
            r_mem[r_tail] <= bus.push_addr;
        end
    end

    assign bus.push_ready = w_push_ready;
    assign bus.pop_valid  = w_pop_valid;
    assign bus.pop_addr   = r_mem[r_head];
    assign bus.lookup_hit = r_lookup_hit;
    assign bus.lookup_idx = r_lookup_idx;
    assign headIdx        = r_head;
    assign tailIdx        = r_tail;
    assign count          = r_count;
    assign empty          = r_empty;
    assign full           = r_full;
    assign dropped        = r_dropped;
endmodule

// File: tb/tb_pf_queue_ctrl.sv
// Scoreboard bench for pf_queue_ctrl: stimulus queues expected pop data and
// lookup results; a monitor compares them as the DUT presents them.
module tb_pf_queue_ctrl;
    localparam int unsigned LOG_DEPTH  = 6;
    localparam int unsigned DEPTH      = 1 << LOG_DEPTH;
    localparam int unsigned ADDR_WIDTH = 64;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic [LOG_DEPTH-1:0] headIdx;
    logic [LOG_DEPTH-1:0] tailIdx;
    logic [LOG_DEPTH:0]   count;
    logic                 empty;
    logic                 full;
    logic                 dropped;

    int errors;
    int checks;

    logic [ADDR_WIDTH-1:0] exp_q[$];
    logic [LOG_DEPTH:0]    lk_q[$];
    logic                  lk_pend;

    pf_queue_if #(.LOG_DEPTH(LOG_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    pf_queue_ctrl #(.LOG_DEPTH(LOG_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .bus     (bus),
        .headIdx (headIdx),
        .tailIdx (tailIdx),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .dropped (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [ADDR_WIDTH-1:0] a);
        bus.push_valid = 1'b1;
        bus.push_addr  = a;
        exp_q.push_back(a);
        cyc();
        bus.push_valid = 1'b0;
    endtask

    task automatic pop1();
        bus.pop_ready = 1'b1;
        cyc();
        bus.pop_ready = 1'b0;
    endtask

    task automatic look1(input logic [ADDR_WIDTH-1:0] a, input logic hit, input logic [LOG_DEPTH-1:0] idx);
        bus.lookup_valid = 1'b1;
        bus.lookup_addr  = a;
        lk_q.push_back({hit, idx});
        cyc();
        bus.lookup_valid = 1'b0;
    endtask

    // Monitor: pop data when a pop will fire, lookup result one cycle after a request
    initial begin
        logic [ADDR_WIDTH-1:0] e;
        logic [LOG_DEPTH:0]    l;
        lk_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (lk_pend) begin
                if (lk_q.size() == 0) begin
                    chk("lookup_unexpected", 64'(bus.lookup_hit), 64'(0));
                end else begin
                    l = lk_q.pop_front();
                    chk("lookup_hit", 64'(bus.lookup_hit), 64'(l[LOG_DEPTH]));
                    if (l[LOG_DEPTH]) chk("lookup_idx", 64'(bus.lookup_idx), 64'(l[LOG_DEPTH-1:0]));
                end
            end
            lk_pend = bus.lookup_valid && !rst;
            if (!rst && !flush && bus.pop_valid && bus.pop_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_underflow", 64'(bus.pop_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_addr", 64'(bus.pop_addr), 64'(e));
                end
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        flush = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_addr = '0;
        bus.pop_ready = 1'b0;
        bus.lookup_valid = 1'b0;
        bus.lookup_addr = '0;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset values
        chk("rst_head", 64'(headIdx), 64'(0));
        chk("rst_tail", 64'(tailIdx), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_pop_valid", 64'(bus.pop_valid), 64'(0));
        chk("rst_push_ready", 64'(bus.push_ready), 64'(1));
        chk("rst_lookup_hit", 64'(bus.lookup_hit), 64'(0));
        chk("rst_lookup_idx", 64'(bus.lookup_idx), 64'(0));
        chk("rst_dropped", 64'(dropped), 64'(0));

        // Fill 0x100..0x13F
        for (int i = 0; i < int'(DEPTH); i++) push1(64'(32'h100 + i));
        chk("fill_full", 64'(full), 64'(1));
        chk("fill_count", 64'(count), 64'(64));
        chk("fill_tail", 64'(tailIdx), 64'(0));
        chk("fill_head", 64'(headIdx), 64'(0));
`ifdef PF_QUEUE_OVERWRITE_EN
        chk("fill_push_ready", 64'(bus.push_ready), 64'(1));
        // Overwrite oldest with 0xFFF
        bus.push_valid = 1'b1;
        bus.push_addr  = 64'h0FFF;
        void'(exp_q.pop_front());
        exp_q.push_back(64'h0FFF);
        cyc();
        bus.push_valid = 1'b0;
        chk("ovw_dropped", 64'(dropped), 64'(1));
        chk("ovw_head", 64'(headIdx), 64'(1));
        chk("ovw_tail", 64'(tailIdx), 64'(1));
        chk("ovw_count", 64'(count), 64'(64));
        cyc();
        chk("ovw_dropped_clear", 64'(dropped), 64'(0));
        for (int i = 0; i < int'(DEPTH); i++) pop1();
        chk("ovw_drain_empty", 64'(empty), 64'(1));
        flush = 1'b1;
        cyc();
        flush = 1'b0;
`else
        chk("fill_push_ready", 64'(bus.push_ready), 64'(0));
        // Push while full alongside a pop: only the pop fires
        bus.push_valid = 1'b1;
        bus.push_addr  = 64'h0DEAD;
        bus.pop_ready  = 1'b1;
        cyc();
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b0;
        chk("full_pushpop_count", 64'(count), 64'(63));
        chk("full_pushpop_tail", 64'(tailIdx), 64'(0));
        chk("full_pushpop_head", 64'(headIdx), 64'(1));
        chk("full_pushpop_dropped", 64'(dropped), 64'(0));
        for (int i = 0; i < int'(DEPTH) - 1; i++) pop1();
`endif
        chk("drain_empty", 64'(empty), 64'(1));
        chk("drain_head", 64'(headIdx), 64'(0));

        // Wrap: 3 in, 3 out, then 64 in
        for (int i = 0; i < 3; i++) push1(64'(32'h200 + i));
        for (int i = 0; i < 3; i++) pop1();
        for (int i = 0; i < int'(DEPTH); i++) push1(64'(32'h300 + i));
        chk("wrap_head", 64'(headIdx), 64'(3));
        chk("wrap_tail", 64'(tailIdx), 64'(3));
        chk("wrap_full", 64'(full), 64'(1));
        for (int i = 0; i < int'(DEPTH); i++) pop1();
        chk("wrap_empty", 64'(empty), 64'(1));

        // Simultaneous push/pop at count 5
        for (int i = 0; i < 5; i++) push1(64'(32'h400 + i));
        bus.pop_ready = 1'b1;
        push1(64'h405);
        bus.pop_ready = 1'b0;
        chk("sim_count", 64'(count), 64'(5));
        chk("sim_head", 64'(headIdx), 64'(4));
        chk("sim_tail", 64'(tailIdx), 64'(9));
        for (int i = 0; i < 5; i++) pop1();
        // Push with pop_ready while empty
        bus.pop_ready = 1'b1;
        push1(64'h500);
        bus.pop_ready = 1'b0;
        chk("empty_pp_count", 64'(count), 64'(1));
        chk("empty_pp_pop_valid", 64'(bus.pop_valid), 64'(1));
        pop1();

        // Lookup: 0xA0,0xB0,0xA0 at slots 2,3,4
        flush = 1'b1;
        exp_q.delete();
        cyc();
        flush = 1'b0;
        push1(64'h1);
        push1(64'h2);
        pop1();
        pop1();
        push1(64'hA0);
        push1(64'hB0);
        push1(64'hA0);
        chk("lk_head", 64'(headIdx), 64'(2));
        look1(64'hA0, 1'b1, 6'd2);
        look1(64'hC0, 1'b0, 6'd0);
        look1(64'hB0, 1'b1, 6'd3);
        look1(64'h1, 1'b0, 6'd0);
        bus.pop_ready = 1'b1;
        look1(64'hA0, 1'b1, 6'd2);
        bus.pop_ready = 1'b0;
        look1(64'hA0, 1'b1, 6'd4);
        cyc();
        chk("lk_idle_hit", 64'(bus.lookup_hit), 64'(0));
        chk("lk_idle_idx", 64'(bus.lookup_idx), 64'(4));

        // Flush while full with push, pop and lookup asserted
        for (int i = 0; i < int'(DEPTH) - 2; i++) push1(64'(32'h600 + i));
        chk("pre_flush_full", 64'(full), 64'(1));
        flush = 1'b1;
        bus.push_valid = 1'b1;
        bus.push_addr = 64'h777;
        bus.pop_ready = 1'b1;
        exp_q.delete();
        look1(64'hB0, 1'b0, 6'd0);
        flush = 1'b0;
        bus.push_valid = 1'b0;
        bus.pop_ready = 1'b0;
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_empty", 64'(empty), 64'(1));
        chk("flush_head", 64'(headIdx), 64'(0));
        chk("flush_tail", 64'(tailIdx), 64'(0));
        chk("flush_lookup_hit", 64'(bus.lookup_hit), 64'(0));

        // Reset mid-operation discards entries
        push1(64'h55);
        push1(64'h66);
        rst = 1'b1;
        exp_q.delete();
        cyc();
        rst = 1'b0;
        chk("midrst_count", 64'(count), 64'(0));
        chk("midrst_pop_valid", 64'(bus.pop_valid), 64'(0));
        chk("midrst_tail", 64'(tailIdx), 64'(0));

        cyc();
        cyc();
        chk("sb_pop_leftover", 64'(exp_q.size()), 64'(0));
        chk("sb_lookup_leftover", 64'(lk_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
